fpl_config_loader: RTL and testbench
====================================

// Module: fpl_config_loader
// PURPOSE
//  Sequencer/arbiter in front of the configurable_logic peripheral. Accepts a framed byte
//  stream (e.g. from UART), issues the 40 config writes (8 functions x 4 input sels + 1 func sel).
//  Shares the peripheral bus with the CPU, so CPU and loader never collide.
//  Sits between the picosoc iomem decode and the configurable_logic instance.
// PARAMETERS
//  NUM_FUNCS       8          function generators to program (max 8, 3-bit index)
//  REGS_PER_FUNC   5          bytes per function: sel0..sel3, func_sel
//  SYNC_BYTE       8'hA5      frame start marker
//  TIMEOUT_CYCLES  1000000    max idle cycles between frame bytes before abort
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  cpu_valid   in   1   CPU request to peripheral
//  cpu_addr    in   16  CPU address
//  cpu_wdata   in   32  CPU write data
//  cpu_wstrb   in   4   CPU byte strobes
//  cpu_ready   out  1   CPU completion pulse
//  cpu_rdata   out  32  passthrough of per_rdata
//  cfg_data    in   8   config stream byte
//  cfg_valid   in   1   byte available
//  cfg_ready   out  1   byte consumed when cfg_valid&cfg_ready
//  per_valid   out  1   peripheral request
//  per_addr    out  16  peripheral address
//  per_wdata   out  32  peripheral write data
//  per_wstrb   out  4   peripheral byte strobes
//  per_ready   in   1   peripheral 1-cycle completion pulse
//  per_rdata   in   32  peripheral read data
//  busy        out  1   frame in progress
//  done        out  1   1-cycle pulse, frame completed (checksum ok or not)
//  err_csum    out  1   sticky: last frame checksum mismatch
//  err_tmo     out  1   sticky: last frame aborted on timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; sticky errors cleared.
//  Frame: SYNC_BYTE, then NUM_FUNCS*REGS_PER_FUNC bytes ordered f0:s0,s1,s2,s3,fn, f1:.., then
//   one checksum byte = XOR of all payload bytes (sync excluded).
//  Payload byte k: fi=k/REGS_PER_FUNC, ri=k%REGS_PER_FUNC (counters, no divider);
//   per_addr={5'b0,fi[2:0],5'b0,ri[2:0]}; per_wdata={24'b0,byte}; per_wstrb=4'b0001.
//  States:
//   IDLE: cfg_ready=1 unless cpu_valid. Non-sync bytes discarded. SYNC_BYTE -> WAIT_BYTE,
//     busy=1, errors cleared, csum=0. cpu_valid (priority over same-cycle sync; cfg_ready=0)
//     -> CPU_XFER.
//   CPU_XFER: per_* = cpu_* registered; per_valid held until per_ready; cpu_ready pulses the
//     cycle after per_ready, same cycle per_valid drops; -> IDLE. Bus is never re-granted in the
//     cycle per_ready is seen.
//   WAIT_BYTE: cfg_ready=1; on accept latch byte, csum^=byte, -> WRITE. No accept for
//     TIMEOUT_CYCLES -> err_tmo=1, busy=0, -> IDLE (partial config stays in peripheral).
//   WRITE: per_valid=1, cfg_ready=0 until per_ready; then advance ri/fi; last payload -> CHECK
//     else WAIT_BYTE. Timeout counter does not run here.
//   CHECK: cfg_ready=1; on accept err_csum=(byte!=csum), done pulse, busy=0, -> IDLE.
//     Timeout applies as in WAIT_BYTE.
//  CPU requests during a frame: cpu_ready held 0, request served after frame ends (IDLE).
//  SYNC_BYTE inside payload is ordinary data (no resync). Timeout counter resets on each accept.
//  cpu_valid dropped by CPU before service: not supported (picosoc holds valid until ready).
//  Reset mid-frame/mid-write: immediate return to IDLE, per_valid=0 next cycle.
// STRUCTURE
//  Package fpl_pkg: state enum, SYNC_BYTE, REGS_PER_FUNC, FUNC_SEL_AND/OR/XOR/NAND codes,
//   address field offsets (func idx [10:8], reg idx [2:0]).
//  One sub-module: fpl_timeout_ctr (load/clear/expire, width $clog2(TIMEOUT_CYCLES+1)).
//  Arbitration and sequencing in one FSM; no extra datapath modules.
// TESTING
//  1) 0xA5 + 40 bytes b=k + csum -> 40 writes addr 0x0000..0x0004,0x0100..0x0704, wdata=k, done, no err.
//  2) Same frame, last byte corrupted -> all 40 writes issued, done, err_csum=1.
//  3) Stop after 10 payload bytes -> err_tmo=1 exactly TIMEOUT_CYCLES after last accept, busy=0.
//  4) cpu_valid write 0x0204=0x01 during frame -> cpu_ready only after done; write seen after write 40.
//  5) cpu_valid and 0xA5 same cycle in IDLE -> CPU served first, then frame proceeds.
//  6) Garbage 0x00,0xFF before sync discarded; rst asserted mid-WRITE -> per_valid=0, IDLE.

Source files
------------

// File: rtl/fpl_pkg.sv
// Shared types and constants for the configurable_logic config loader.
package fpl_pkg;

  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
  localparam int unsigned REGS_PER_FUNC = 5;
  localparam int unsigned IDX_W         = 3;

  // Address field offsets inside the peripheral register map.
  localparam int unsigned ADDR_FUNC_LSB = 8;
  localparam int unsigned ADDR_REG_LSB  = 0;

  localparam logic [7:0] FUNC_SEL_AND  = 8'h00;
  localparam logic [7:0] FUNC_SEL_OR   = 8'h01;
  localparam logic [7:0] FUNC_SEL_XOR  = 8'h02;
  localparam logic [7:0] FUNC_SEL_NAND = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_XFER,
    ST_WAIT_BYTE,
    ST_WRITE,
    ST_CHECK
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  function automatic logic [15:0] cfg_addr(input logic [IDX_W-1:0] fi,
                                           input logic [IDX_W-1:0] ri);
    logic [15:0] a;
    a = '0;
    a[ADDR_FUNC_LSB +: IDX_W] = fi;
    a[ADDR_REG_LSB  +: IDX_W] = ri;
    return a;
  endfunction

endpackage

// File: rtl/fpl_timeout_ctr.sv
// Idle-cycle counter: counts while run is high, clears otherwise, flags the
// TIMEOUT_CYCLES-th consecutive running cycle.
module fpl_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || !run) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

  assign expire_c = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpl_config_loader.sv
// Frames a config byte stream into peripheral register writes and arbitrates
// the shared peripheral bus with the CPU.
module fpl_config_loader
  import fpl_pkg::*;
#(
  parameter int unsigned NUM_FUNCS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid,
  input  logic [15:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic [7:0]  cfg_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic        per_valid,
  output logic [15:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wstrb,
  input  logic        per_ready,
  input  logic [31:0] per_rdata,
  output logic        busy,
  output logic        done,
  output logic        err_csum,
  output logic        err_tmo
);

  state_t           state, state_d;
  logic [IDX_W-1:0] fi, fi_d, ri, ri_d;
  logic [7:0]       csum, csum_d;
  bus_req_t         req, req_d;
  logic             per_valid_d, cpu_ready_d, busy_d, done_d;
  logic             err_csum_d, err_tmo_d;
  logic [31:0]      cpu_rdata_d;

  logic accept, cpu_req, last_payload, tmo_run, tmo_expire;

  // Combinational so a CPU request blocks a same-cycle sync byte.
  assign cfg_ready = !rst && (((state == ST_IDLE) && !cpu_valid) ||
                              (state == ST_WAIT_BYTE) || (state == ST_CHECK));
  assign accept    = cfg_valid && cfg_ready;
  // cpu_valid is still high in the cycle cpu_ready pulses; do not re-grant it.
  assign cpu_req   = cpu_valid && !cpu_ready;
  assign last_payload = (fi == IDX_W'(NUM_FUNCS - 1)) && (ri == IDX_W'(REGS_PER_FUNC - 1));
  assign tmo_run   = ((state == ST_WAIT_BYTE) || (state == ST_CHECK)) && !accept;

  fpl_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .run      (tmo_run),
    .expire_c (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fi        <= '0;
      ri        <= '0;
      csum      <= '0;
      req       <= '0;
      per_valid <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_csum  <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      state     <= state_d;
      fi        <= fi_d;
      ri        <= ri_d;
      csum      <= csum_d;
      req       <= req_d;
      per_valid <= per_valid_d;
      cpu_ready <= cpu_ready_d;
      cpu_rdata <= cpu_rdata_d;
      busy      <= busy_d;
      done      <= done_d;
      err_csum  <= err_csum_d;
      err_tmo   <= err_tmo_d;
    end
  end

  always_comb begin
    state_d     = state;
    fi_d        = fi;
    ri_d        = ri;
    csum_d      = csum;
    req_d       = req;
    per_valid_d = per_valid;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata;
    busy_d      = busy;
    done_d      = 1'b0;
    err_csum_d  = err_csum;
    err_tmo_d   = err_tmo;
    unique case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          req_d       = '{addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
          per_valid_d = 1'b1;
          state_d     = ST_CPU_XFER;
        end else if (accept && (cfg_data == SYNC_BYTE)) begin
          fi_d       = '0;
          ri_d       = '0;
          csum_d     = '0;
          busy_d     = 1'b1;
          err_csum_d = 1'b0;
          err_tmo_d  = 1'b0;
          state_d    = ST_WAIT_BYTE;
        end
      end
      ST_CPU_XFER: begin
        // Read data is captured so it lines up with the cpu_ready pulse.
        if (per_ready) begin
          per_valid_d = 1'b0;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = per_rdata;
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT_BYTE: begin
        if (accept) begin
          csum_d      = csum ^ cfg_data;
          req_d       = '{addr: cfg_addr(fi, ri), wdata: {24'b0, cfg_data}, wstrb: 4'b0001};
          per_valid_d = 1'b1;
          state_d     = ST_WRITE;
        end else if (tmo_expire) begin
          err_tmo_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (per_ready) begin
          per_valid_d = 1'b0;
          if (ri == IDX_W'(REGS_PER_FUNC - 1)) begin
            ri_d = '0;
            fi_d = fi + IDX_W'(1);
          end else begin
            ri_d = ri + IDX_W'(1);
          end
          state_d = last_payload ? ST_CHECK : ST_WAIT_BYTE;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          err_csum_d = (cfg_data != csum);
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (tmo_expire) begin
          err_tmo_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign per_addr  = req.addr;
  assign per_wdata = req.wdata;
  assign per_wstrb = req.wstrb;

endmodule

// File: tb/tb_fpl_config_loader.sv
// Randomized bench for fpl_config_loader with a transaction-level frame model
// and a few hand-computed anchors.
module tb_fpl_config_loader;

  localparam int T     = 64;
  localparam int NPAY  = 40;
  localparam int BOUND = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [7:0]  cfg_data = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        per_valid;
  logic [15:0] per_addr;
  logic [31:0] per_wdata;
  logic [3:0]  per_wstrb;
  logic        per_ready = 1'b0;
  logic [31:0] per_rdata = '0;
  logic        busy, done, err_csum, err_tmo;

  always #5 clk = ~clk;

  fpl_config_loader #(.NUM_FUNCS(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .per_valid(per_valid), .per_addr(per_addr), .per_wdata(per_wdata), .per_wstrb(per_wstrb),
    .per_ready(per_ready), .per_rdata(per_rdata),
    .busy(busy), .done(done), .err_csum(err_csum), .err_tmo(err_tmo)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Peripheral: random 0..3 cycle response latency, can be stalled.
  logic per_stall = 1'b0;
  int   pdelay = 0;
  always begin
    @(posedge clk);
    #1;
    per_ready = 1'b0;
    if (per_valid && !rst && !per_stall) begin
      if (pdelay == 0) begin
        per_ready = 1'b1;
        per_rdata = $urandom;
        pdelay    = $urandom_range(0, 3);
      end else begin
        pdelay--;
      end
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;
  wr_t wlog[$];
  int  dut_done_cnt = 0;
  int  done_cyc = 0;
  int  cpu_ready_cyc = 0;

  // Frame model: position in frame, running XOR, outstanding write, idle cycles.
  bit          in_frame = 0;
  int          pos = 0;
  logic [7:0]  xsum = '0;
  int          outstanding = 0;
  int          idle_cnt = 0;
  logic [15:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_busy = 0, exp_done = 0, exp_err_csum = 0, exp_err_tmo = 0;
  logic        exp_cpu_ready = 0, exp_pv_low = 0;
  logic [31:0] exp_rdata = '0;

  always @(negedge clk) begin : monitor
    bit acc, hs, wait_now;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("err_csum", 32'(err_csum), 32'(exp_err_csum));
    chk("err_tmo", 32'(err_tmo), 32'(exp_err_tmo));
    chk("cpu_ready", 32'(cpu_ready), 32'(exp_cpu_ready));
    if (exp_cpu_ready) chk("cpu_rdata", cpu_rdata, exp_rdata);
    if (exp_pv_low) chk("per_valid_after_rst", 32'(per_valid), 32'd0);
    if (rst) chk("cfg_ready_in_rst", 32'(cfg_ready), 32'd0);
    else if (in_frame) begin
      chk("cfg_ready_frame", 32'(cfg_ready), 32'(outstanding == 0));
      chk("per_valid_frame", 32'(per_valid), 32'(outstanding != 0));
    end else if (cpu_valid) chk("cfg_ready_cpu_prio", 32'(cfg_ready), 32'd0);
    if (done) begin dut_done_cnt++; done_cyc = cyc; end
    if (cpu_ready) cpu_ready_cyc = cyc;

    exp_done = 0;
    exp_cpu_ready = 0;
    exp_pv_low = 0;
    if (rst) begin
      in_frame = 0; pos = 0; outstanding = 0; idle_cnt = 0;
      exp_busy = 0; exp_err_csum = 0; exp_err_tmo = 0; exp_pv_low = 1;
    end else begin
      acc = cfg_valid && cfg_ready;
      hs = per_valid && per_ready;
      wait_now = in_frame && (outstanding == 0);
      if (hs) begin
        wlog.push_back('{per_addr, per_wdata, per_wstrb});
        if (in_frame) begin
          chk("frame_write_expected", 32'(outstanding), 32'd1);
          chk("frame_addr", 32'(per_addr), 32'(exp_addr));
          chk("frame_wdata", per_wdata, exp_data);
          chk("frame_wstrb", 32'(per_wstrb), 32'h1);
          outstanding = 0;
        end else if (cpu_valid) begin
          chk("cpu_addr_pass", 32'(per_addr), 32'(cpu_addr));
          chk("cpu_wdata_pass", per_wdata, cpu_wdata);
          chk("cpu_wstrb_pass", 32'(per_wstrb), 32'(cpu_wstrb));
          exp_cpu_ready = 1;
          exp_rdata = per_rdata;
        end else begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h expected no write (cycle %0d)", per_addr, cyc);
        end
      end
      if (acc) begin
        idle_cnt = 0;
        if (!in_frame) begin
          if (cfg_data == 8'hA5) begin
            in_frame = 1; pos = 0; xsum = '0;
            exp_busy = 1; exp_err_csum = 0; exp_err_tmo = 0;
          end
        end else if (pos < NPAY) begin
          exp_addr = 16'((pos / 5) * 256 + (pos % 5));
          exp_data = {24'b0, cfg_data};
          xsum = xsum ^ cfg_data;
          pos++;
          outstanding = 1;
        end else begin
          exp_err_csum = (cfg_data != xsum);
          exp_done = 1;
          exp_busy = 0;
          in_frame = 0;
        end
      end else if (wait_now) begin
        idle_cnt++;
        if (idle_cnt == T) begin
          in_frame = 0; exp_busy = 0; exp_err_tmo = 1; idle_cnt = 0;
        end
      end else begin
        idle_cnt = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    int n;
    repeat (gap) tick();
    cfg_data = b;
    cfg_valid = 1'b1;
    got = 0;
    n = 0;
    while (!got && n < BOUND) begin
      @(negedge clk);
      got = cfg_ready;
      tick();
      n++;
    end
    cfg_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL cfg_accept_wait: got no accept expected accept within %0d cycles", BOUND);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    int n;
    cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_valid = 1'b1;
    got = 0;
    n = 0;
    while (!got && n < BOUND) begin
      @(negedge clk);
      got = cpu_ready;
      tick();
      n++;
    end
    cpu_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL cpu_ready_wait: got no cpu_ready expected within %0d cycles", BOUND);
    end
  endtask

  typedef logic [7:0] payload_t [NPAY];

  task automatic send_frame(input payload_t pl, input logic [7:0] csum, input int npay);
    send_byte(8'hA5, 0);
    for (int k = 0; k < npay; k++) send_byte(pl[k], $urandom_range(0, 3));
    if (npay == NPAY) send_byte(csum, $urandom_range(0, 3));
  endtask

  payload_t ramp, rnd;
  int base, dcnt;
  logic [7:0] x;

  initial begin
    for (int k = 0; k < NPAY; k++) ramp[k] = 8'(k);
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_per_valid", 32'(per_valid), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_errs", {30'b0, err_csum, err_tmo}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    // Garbage before sync, then ramp frame; XOR of 0..39 is 0x00.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    base = wlog.size();
    dcnt = dut_done_cnt;
    send_frame(ramp, 8'h00, NPAY);
    tick();
    chk("t1_nwrites", 32'(wlog.size() - base), 32'd40);
    chk("t1_addr0", 32'(wlog[base].addr), 32'h0000);
    chk("t1_addr4", 32'(wlog[base+4].addr), 32'h0004);
    chk("t1_addr5", 32'(wlog[base+5].addr), 32'h0100);
    chk("t1_addr39", 32'(wlog[base+39].addr), 32'h0704);
    chk("t1_data39", wlog[base+39].data, 32'd39);
    chk("t1_strb", 32'(wlog[base+17].strb), 32'h1);
    chk("t1_done", 32'(dut_done_cnt - dcnt), 32'd1);
    chk("t1_err_csum", 32'(err_csum), 32'd0);

    // Corrupted checksum.
    base = wlog.size();
    send_frame(ramp, 8'h01, NPAY);
    tick();
    chk("t2_nwrites", 32'(wlog.size() - base), 32'd40);
    chk("t2_err_csum", 32'(err_csum), 32'd1);

    // Timeout after 10 payload bytes.
    base = wlog.size();
    send_frame(ramp, 8'h00, 10);
    for (int n = 0; n < T + 40 && !err_tmo; n++) tick();
    chk("t3_err_tmo", 32'(err_tmo), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_nwrites", 32'(wlog.size() - base), 32'd10);
    chk("t3_err_csum_cleared", 32'(err_csum), 32'd0);

    // CPU write during a frame waits for the frame to finish.
    base = wlog.size();
    fork
      send_frame(ramp, 8'h00, NPAY);
      begin repeat (20) tick(); cpu_write(16'h0204, 32'h1, 4'b0001); end
    join
    chk("t4_order", 32'(cpu_ready_cyc > done_cyc), 32'd1);
    chk("t4_nwrites", 32'(wlog.size() - base), 32'd41);
    chk("t4_cpu_addr", 32'(wlog[base+40].addr), 32'h0204);
    chk("t4_cpu_data", wlog[base+40].data, 32'h1);

    // CPU request and sync byte in the same idle cycle.
    base = wlog.size();
    fork
      cpu_write(16'h0010, 32'hDEADBEEF, 4'hF);
      send_frame(ramp, 8'h00, NPAY);
    join
    tick();
    chk("t5_cpu_first", 32'(wlog[base].addr), 32'h0010);
    chk("t5_nwrites", 32'(wlog.size() - base), 32'd41);
    chk("t5_err_csum", 32'(err_csum), 32'd0);

    // Reset while a write is stalled on the bus.
    per_stall = 1'b1;
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    repeat (3) tick();
    chk("t6_stalled_pv", 32'(per_valid), 32'd1);
    chk("t6_stalled_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_pv", 32'(per_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    per_stall = 1'b0;
    tick();
    base = wlog.size();
    send_frame(ramp, 8'h00, NPAY);
    tick();
    chk("t6_recover_nwrites", 32'(wlog.size() - base), 32'd40);
    chk("t6_recover_csum", 32'(err_csum), 32'd0);

    // Random frames, garbage and CPU traffic checked against the model.
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 3)) begin
        x = 8'($urandom);
        if (x == 8'hA5) x = 8'h5A;
        send_byte(x, $urandom_range(0, 2));
      end
      x = '0;
      for (int k = 0; k < NPAY; k++) begin
        rnd[k] = 8'($urandom);
        x = x ^ rnd[k];
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      fork
        send_frame(rnd, x, NPAY);
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(0, 150)) tick();
          cpu_write(16'($urandom), $urandom, 4'($urandom));
        end
      join
      repeat (2) tick();
    end

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
